// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage ARM pipeline: operand forwarding, load-use and
// PC-write stalls, branch flushes, a two-phase long-multiply sequencer and a stall counter.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             LongE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             LongHiE,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_long_stall;
  logic             w_ldr_stall;
  logic             w_pc_wr_pending;
  logic [CNT_W-1:0] r_stall_count;

  // Memory-stage result is newer than Writeback, so it is checked first.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W))
      ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W))
      ForwardBE = 2'b01;
  end

  assign w_ldr_stall     = MemToRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign w_pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // HI always lasts one cycle and ignores LongE, so each long multiply gets its own pair.
  always_comb begin
    w_state_next = r_state;
    w_long_stall = 1'b0;
    LongHiE      = 1'b0;
    case (r_state)
      IDLE: begin
        if (LongE) begin
          w_long_stall = 1'b1;
          w_state_next = HI;
        end
      end
      HI: begin
        LongHiE      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign StallF = w_ldr_stall | w_pc_wr_pending | w_long_stall;
  assign StallD = w_ldr_stall | w_long_stall;
  assign StallE = w_long_stall;
  assign FlushD = w_pc_wr_pending | PCSrcW | BranchTakenE;
  // A stalled Execute register must keep its instruction, so stall overrides flush.
  assign FlushE = (w_ldr_stall | BranchTakenE) & ~w_long_stall;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if (StallF && (r_stall_count != {CNT_W{1'b1}}))
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed test-plan scenarios with literal
// expectations plus randomized stimulus compared every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemToRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, LongHiE;
  logic [CNT_W-1:0] StallCount;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: "second phase of a long multiply is in Execute" and the stall tally.
  bit m_hi  = 1'b0;
  int m_cnt = 0;

  logic [1:0] e_fa, e_fb;
  logic       e_ldr, e_pcw, e_long, e_sf, e_sd, e_se, e_fd, e_fe;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .LongE(LongE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .LongHiE(LongHiE),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // Expected outputs straight from the hazard rules.
  always_comb begin
    e_fa = 2'd0;
    e_fb = 2'd0;
    if (RegWriteM && RA1E == WA3M) e_fa = 2'd2;
    else if (RegWriteW && RA1E == WA3W) e_fa = 2'd1;
    if (RegWriteM && RA2E == WA3M) e_fb = 2'd2;
    else if (RegWriteW && RA2E == WA3W) e_fb = 2'd1;
    e_ldr  = MemToRegE && (RA1D == WA3E || RA2D == WA3E);
    e_pcw  = PCSrcD || PCSrcE || PCSrcM;
    e_long = !m_hi && LongE;
    e_sf   = e_ldr || e_pcw || e_long;
    e_sd   = e_ldr || e_long;
    e_se   = e_long;
    e_fd   = e_pcw || PCSrcW || BranchTakenE;
    e_fe   = (e_ldr || BranchTakenE) && !e_se;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_hi  = 1'b0;
      m_cnt = 0;
    end else begin
      if (e_sf && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_hi = e_long;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      assert (!(e_ldr && e_long)) else $error("load-use and long stall overlap");
      chk("m.ForwardAE", int'(ForwardAE), int'(e_fa));
      chk("m.ForwardBE", int'(ForwardBE), int'(e_fb));
      chk("m.StallF", int'(StallF), int'(e_sf));
      chk("m.StallD", int'(StallD), int'(e_sd));
      chk("m.StallE", int'(StallE), int'(e_se));
      chk("m.FlushD", int'(FlushD), int'(e_fd));
      chk("m.FlushE", int'(FlushE), int'(e_fe));
      chk("m.LongHiE", int'(LongHiE), int'(m_hi));
      chk("m.StallCount", int'(StallCount), m_cnt);
    end
  end

  task automatic clr();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemToRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE} = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (2) nxt();
    reset = 1'b0;
    cmp_en = 1'b1;
    smp();
    chk("rst.StallF", int'(StallF), 0);
    chk("rst.FlushD", int'(FlushD), 0);
    chk("rst.FlushE", int'(FlushE), 0);
    chk("rst.LongHiE", int'(LongHiE), 0);
    chk("rst.StallCount", int'(StallCount), 0);
    $display("txn reset: StallCount=%0d LongHiE=%0d", StallCount, LongHiE);

    // Forwarding priority
    nxt(); RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
    smp(); chk("fwd.mem_prio", int'(ForwardAE), 2);
    $display("txn fwd M+W match: ForwardAE=%b", ForwardAE);
    nxt(); RegWriteM = 0;
    smp(); chk("fwd.wb", int'(ForwardAE), 1);
    chk("fwd.B_none", int'(ForwardBE), 0);
    $display("txn fwd W match: ForwardAE=%b ForwardBE=%b", ForwardAE, ForwardBE);

    // Load-use
    nxt(); clr(); MemToRegE = 1; WA3E = 5; RA2D = 5;
    smp();
    chk("ldr.StallF", int'(StallF), 1);
    chk("ldr.StallD", int'(StallD), 1);
    chk("ldr.FlushE", int'(FlushE), 1);
    chk("ldr.cnt_before", int'(StallCount), 0);
    nxt(); clr();
    smp(); chk("ldr.cnt_after", int'(StallCount), 1);
    $display("txn load-use: StallCount=%0d", StallCount);

    // Branch and PC writes
    nxt(); BranchTakenE = 1;
    smp();
    chk("br.FlushD", int'(FlushD), 1);
    chk("br.FlushE", int'(FlushE), 1);
    chk("br.StallF", int'(StallF), 0);
    nxt(); BranchTakenE = 0; PCSrcD = 1;
    smp(); chk("pcD.StallF", int'(StallF), 1); chk("pcD.FlushD", int'(FlushD), 1);
    nxt(); PCSrcD = 0; PCSrcE = 1;
    smp(); chk("pcE.StallF", int'(StallF), 1); chk("pcE.FlushD", int'(FlushD), 1);
    nxt(); PCSrcE = 0; PCSrcM = 1;
    smp(); chk("pcM.StallF", int'(StallF), 1); chk("pcM.FlushD", int'(FlushD), 1);
    nxt(); PCSrcM = 0; PCSrcW = 1;
    smp(); chk("pcW.StallF", int'(StallF), 0); chk("pcW.FlushD", int'(FlushD), 1);
    chk("pc.cnt", int'(StallCount), 4);
    $display("txn branch/pc: StallCount=%0d", StallCount);

    // Long multiply with a branch forced alongside phase 1
    nxt(); clr(); LongE = 1; BranchTakenE = 1;
    smp();
    chk("lm1.StallF", int'(StallF), 1);
    chk("lm1.StallD", int'(StallD), 1);
    chk("lm1.StallE", int'(StallE), 1);
    chk("lm1.FlushE", int'(FlushE), 0);
    chk("lm1.LongHiE", int'(LongHiE), 0);
    nxt(); clr();
    smp();
    chk("lm2.LongHiE", int'(LongHiE), 1);
    chk("lm2.StallF", int'(StallF), 0);
    chk("lm2.StallE", int'(StallE), 0);
    nxt();
    smp();
    chk("lm3.LongHiE", int'(LongHiE), 0);
    chk("lm3.cnt", int'(StallCount), 5);
    $display("txn long multiply: StallCount=%0d", StallCount);

    // Back-to-back long multiplies
    nxt(); LongE = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("b2b.LongHiE", int'(LongHiE), i % 2);
      $display("txn b2b cycle %0d: LongHiE=%0d", i, LongHiE);
      if (i < 3) nxt();
    end

    // Reset while in HI
    nxt(); LongE = 0;
    nxt(); LongE = 1;
    nxt(); LongE = 0; reset = 1;
    smp(); chk("rstHI.LongHiE_pre", int'(LongHiE), 1);
    nxt(); reset = 0;
    smp();
    chk("rstHI.LongHiE", int'(LongHiE), 0);
    chk("rstHI.cnt", int'(StallCount), 0);
    $display("txn reset in HI: LongHiE=%0d StallCount=%0d", LongHiE, StallCount);

    // Saturation
    nxt(); PCSrcD = 1;
    repeat (CNT_MAX + 20) nxt();
    smp(); chk("sat.cnt", int'(StallCount), CNT_MAX);
    repeat (10) nxt();
    smp(); chk("sat.hold", int'(StallCount), CNT_MAX);
    $display("txn saturation: StallCount=%0d", StallCount);

    // Randomized traffic; small address range keeps matches frequent
    nxt(); clr(); reset = 1;
    nxt(); reset = 0;
    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset        = ($urandom_range(0, 63) == 0);
      RA1D         = 4'($urandom_range(0, 3));
      RA2D         = 4'($urandom_range(0, 3));
      RA1E         = 4'($urandom_range(0, 3));
      RA2E         = 4'($urandom_range(0, 3));
      WA3E         = 4'($urandom_range(0, 3));
      WA3M         = 4'($urandom_range(0, 3));
      WA3W         = 4'($urandom_range(0, 3));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      PCSrcD       = ($urandom_range(0, 7) == 0);
      PCSrcE       = ($urandom_range(0, 7) == 0);
      PCSrcM       = ($urandom_range(0, 7) == 0);
      PCSrcW       = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      LongE        = ($urandom_range(0, 3) == 0);
      MemToRegE    = !LongE && ($urandom_range(0, 2) == 0);
    end
    smp();
    $display("txn random: %0d cycles done", 3000);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
